bp_cce_fill_sender: RTL and testbench
=====================================

# bp_cce_fill_sender

Transmit side of the BedRock LCE Fill channel. It accepts a block fill request (address, size, destination LCE, way, coherence state, full block data). It emits one `e_bedrock_fill_data` header followed by a wraparound-ordered burst of fill data beats. It then tracks the outstanding coherence acknowledgements (`e_bedrock_resp_coh_ack`) returned on the LCE Response channel. It sits in the CCE next to the memory-response path and drives the same header/data burst interface that an LCE fill handler consumes.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `lce_id_width_p`, `cce_id_width_p`, `lce_assoc_p`.
- `block_width_p`, 512: cache block width in bits.
- `fill_width_p`, 64: data beat width; `N = block_width_p/fill_width_p` beats per block; `fill_bytes = fill_width_p/8`.
- `pending_els_p`, 2: maximum fills awaiting coh_ack; counter width `clog2(pending_els_p+1)`.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `cce_id_i` in `cce_id_width_p`: placed in header `payload.src_id`.
- `req_v_i` in 1, `req_ready_and_o` out 1: request handshake (ready&valid).
- `req_addr_i` in `paddr_width_p`: request address.
- `req_size_i` in 3: `bp_bedrock_msg_size_e`.
- `req_lce_id_i` in `lce_id_width_p`: destination LCE.
- `req_way_id_i` in `lce_assoc_p` bits: target way.
- `req_state_i` in `$bits(bp_coh_states_e)`: coherence state.
- `req_data_i` in `block_width_p`: block data; beat k is `[k*fill_width_p +: fill_width_p]`.
- `lce_fill_header_o` out `lce_fill_header_width_lp`, `lce_fill_header_v_o` out 1, `lce_fill_header_ready_and_i` in 1: fill header handshake.
- `lce_fill_has_data_o` out 1: fill carries data.
- `lce_fill_data_o` out `fill_width_p`, `lce_fill_data_v_o` out 1, `lce_fill_data_ready_and_i` in 1: fill data beat handshake.
- `lce_fill_last_o` out 1: final beat of the burst.
- `lce_resp_header_i` in `lce_resp_header_width_lp`, `lce_resp_header_v_i` in 1, `lce_resp_header_ready_and_o` out 1: response header handshake.
- `lce_resp_has_data_i` in 1: response carries data.
- `ack_v_o` out 1, `ack_lce_id_o` out `lce_id_width_p`, `ack_addr_o` out `paddr_width_p`: one-cycle coh_ack notification.
- `pending_o` out counter width: outstanding fill count.
- `error_o` out 1: sticky protocol error.

## Operation
- FSM states: `e_reset`, `e_ready`, `e_header`, `e_data`.
  - `e_reset` goes to `e_ready` after one cycle.
- `req_ready_and_o = (state_r==e_ready) & (pending_r < pending_els_p)`.
  - On handshake, all `req_*` fields are captured into registers.
  - FSM goes to `e_header`.
- Header contents in `e_header`:
  - `msg_type.fill = e_bedrock_fill_data`; `addr`, `size` taken from the captured request.
  - `payload.{src_id=cce_id_i, dst_id, way_id, state}`.
  - `lce_fill_has_data_o=1`; `lce_fill_header_v_o=1`.
  - On header handshake: `pending_r` increments, the beat counter loads, and the FSM goes to `e_data`.
- Beat math:
  - `n = max((1<<size)/fill_bytes, 1)`, clamped to N.
  - `first = addr[clog2(fill_bytes) +: clog2(N)]`.
  - Beat i (0..n-1) selects index `(first & ~(n-1)) | ((first+i) & (n-1))`.
- `e_data`:
  - `lce_fill_data_v_o=1`.
  - Counter advances only on a data handshake.
  - `lce_fill_last_o=1` exactly when i==n-1.
  - Handshake on the last beat returns the FSM to `e_ready`.
- Response side:
  - `lce_resp_header_ready_and_o=1` whenever not in reset.
  - A consumed coh_ack with `has_data=0` and `pending_r>0` decrements `pending_r`. The same cycle, it pulses `ack_v_o` with `ack_addr_o=addr` and `ack_lce_id_o=payload.src_id`.
- Errors set `error_o`, which clears only on reset:
  - Any consumed response that is not coh_ack.
  - A coh_ack with `has_data=1`.
  - A coh_ack with `pending_r==0`.
  - In all three cases the response is dropped, no `ack_v_o` pulse is raised, and the counter is unchanged.
- Simultaneous header handshake and valid coh_ack: `pending_r` is unchanged.

## Timing
- Reset values:
  - State `e_reset`; `pending_r=0`; `error_o=0`.
  - All `*_v_o`, `req_ready_and_o`, `ack_v_o`, `lce_fill_last_o`, `lce_fill_has_data_o` are 0.
  - Data and header outputs are 0.
- Reset mid-burst abandons the burst immediately, with no further beats.
- Request accepted at cycle t: header valid at t+1.
- Zero backpressure:
  - First beat is valid the cycle after the header handshake.
  - One beat per cycle after that.
  - Next request is accepted the cycle after the last beat.
- Valid outputs stay stable until their handshake completes.
- `ack_v_o` is combinational with the response handshake.
- `pending_o` updates on the next edge.

## Configuration
- `BP_CCE_FILL_CRITICAL_FIRST_EN` defined: `first` is as in Operation, giving critical-beat-first wraparound.
- Not defined: `first` is forced to `first & ~(n-1)`, so beats go out in ascending aligned order. The header address is unchanged in both cases.

## Test plan
Configuration for all scenarios: 512/64, N=8.
- 64B fill at addr 0x8000_0018, data words D0..D7:
  - Macro on: beats D3,D4,D5,D6,D7,D0,D1,D2, last only on D2.
  - Macro off: beats D0..D7, last only on D7.
- 8B fill at addr 0x28 -> exactly one beat D5 with `last=1`. 16B fill at addr 0x38 (macro on) -> beats D7 then D6.
- Random toggling of `lce_fill_data_ready_and_i` during a 64B fill -> 8 beats, none skipped or duplicated, order correct, data stable while stalled.
- `pending_els_p=2`: two fills with no acks -> `pending_o=2`, `req_ready_and_o=0`. Send one coh_ack -> `ack_v_o` pulses with the matching addr and lce_id, and `req_ready_and_o=1` the next cycle.
- With `pending_o=1`: coh_ack arrives in the same cycle as the next header handshake -> `pending_o` stays 1 and `ack_v_o` pulses.
- coh_ack at `pending_o=0`, or a response of any other type -> `error_o=1` held until `reset_i`, no `ack_v_o` pulse, counter stays 0.

Source files
------------

// File: rtl/bp_cce_fill_sender.sv
// bp_cce_fill_sender: BedRock LCE fill header + wrapped data burst, coh_ack tracking.
// Option macro BP_CCE_FILL_CRITICAL_FIRST_EN: critical-beat-first burst order.

package bp_cce_fill_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0
    } bp_params_e;

    localparam int paddr_width_gp  = 40;
    localparam int lce_id_width_gp = 4;
    localparam int cce_id_width_gp = 4;
    localparam int lce_assoc_gp    = 8;

    typedef struct packed {
        int paddr_width;
        int lce_id_width;
        int cce_id_width;
        int lce_assoc;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_get_proc_param(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_default_cfg: begin
                p.paddr_width  = paddr_width_gp;
                p.lce_id_width = lce_id_width_gp;
                p.cce_id_width = cce_id_width_gp;
                p.lce_assoc    = lce_assoc_gp;
            end
            default: begin
                p.paddr_width  = paddr_width_gp;
                p.lce_id_width = lce_id_width_gp;
                p.cce_id_width = cce_id_width_gp;
                p.lce_assoc    = lce_assoc_gp;
            end
        endcase
        return p;
    endfunction

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_F = 3'd3,
        e_COH_M = 3'd6,
        e_COH_O = 3'd7
    } bp_coh_states_e;

    typedef enum logic [3:0] {
        e_bedrock_fill_null = 4'd0,
        e_bedrock_fill_data = 4'd1
    } bp_bedrock_fill_type_e;

    typedef enum logic [3:0] {
        e_bedrock_resp_sync_ack = 4'd0,
        e_bedrock_resp_inv_ack  = 4'd1,
        e_bedrock_resp_coh_ack  = 4'd2,
        e_bedrock_resp_wb       = 4'd3,
        e_bedrock_resp_null_wb  = 4'd4
    } bp_bedrock_resp_type_e;

    typedef struct packed {
        logic [cce_id_width_gp-1:0] src_id;
        logic [lce_id_width_gp-1:0] dst_id;
        logic [lce_assoc_gp-1:0]    way_id;
        bp_coh_states_e             state;
    } bp_bedrock_fill_payload_s;

    typedef struct packed {
        bp_bedrock_fill_payload_s   payload;
        bp_bedrock_msg_size_e       size;
        logic [paddr_width_gp-1:0]  addr;
        bp_bedrock_fill_type_e      msg_type;
    } bp_bedrock_fill_header_s;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] src_id;
        logic [cce_id_width_gp-1:0] dst_id;
    } bp_bedrock_resp_payload_s;

    typedef struct packed {
        bp_bedrock_resp_payload_s   payload;
        bp_bedrock_msg_size_e       size;
        logic [paddr_width_gp-1:0]  addr;
        bp_bedrock_resp_type_e      msg_type;
    } bp_bedrock_resp_header_s;

endpackage

module bp_cce_fill_sender
    import bp_cce_fill_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int block_width_p = 512,
    parameter int fill_width_p  = 64,
    parameter int pending_els_p = 2,
    localparam bp_proc_param_s proc_lp = bp_get_proc_param(bp_params_p),
    localparam int paddr_width_p  = proc_lp.paddr_width,
    localparam int lce_id_width_p = proc_lp.lce_id_width,
    localparam int cce_id_width_p = proc_lp.cce_id_width,
    localparam int lce_assoc_p    = proc_lp.lce_assoc,
    localparam int pend_w_lp      = $clog2(pending_els_p+1),
    localparam int lce_fill_header_width_lp = $bits(bp_bedrock_fill_header_s),
    localparam int lce_resp_header_width_lp = $bits(bp_bedrock_resp_header_s)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [cce_id_width_p-1:0]           cce_id_i,

    input  logic                                req_v_i,
    output logic                                req_ready_and_o,
    input  logic [paddr_width_p-1:0]            req_addr_i,
    input  logic [2:0]                          req_size_i,
    input  logic [lce_id_width_p-1:0]           req_lce_id_i,
    input  logic [lce_assoc_p-1:0]              req_way_id_i,
    input  logic [$bits(bp_coh_states_e)-1:0]   req_state_i,
    input  logic [block_width_p-1:0]            req_data_i,

    output logic [lce_fill_header_width_lp-1:0] lce_fill_header_o,
    output logic                                lce_fill_header_v_o,
    input  logic                                lce_fill_header_ready_and_i,
    output logic                                lce_fill_has_data_o,
    output logic [fill_width_p-1:0]             lce_fill_data_o,
    output logic                                lce_fill_data_v_o,
    input  logic                                lce_fill_data_ready_and_i,
    output logic                                lce_fill_last_o,

    input  logic [lce_resp_header_width_lp-1:0] lce_resp_header_i,
    input  logic                                lce_resp_header_v_i,
    output logic                                lce_resp_header_ready_and_o,
    input  logic                                lce_resp_has_data_i,

    output logic                                ack_v_o,
    output logic [lce_id_width_p-1:0]           ack_lce_id_o,
    output logic [paddr_width_p-1:0]            ack_addr_o,
    output logic [pend_w_lp-1:0]                pending_o,
    output logic                                error_o
);

    localparam int fill_bytes_lp = fill_width_p/8;
    localparam int beats_lp      = block_width_p/fill_width_p;
    localparam int lg_fb_lp      = $clog2(fill_bytes_lp);
    localparam int lg_beats_lp   = $clog2(beats_lp);
    localparam int cnt_w_lp      = (lg_beats_lp > 0) ? lg_beats_lp : 1;

    typedef enum logic [1:0] {
        e_reset,
        e_ready,
        e_header,
        e_data
    } state_e;

    state_e state_r, state_n;

    logic [paddr_width_p-1:0]  addr_r;
    bp_bedrock_msg_size_e      size_r;
    logic [lce_id_width_p-1:0] lce_r;
    logic [lce_assoc_p-1:0]    way_r;
    bp_coh_states_e            coh_r;
    logic [block_width_p-1:0]  data_r;
    logic [cnt_w_lp-1:0]       first_r;
    logic [cnt_w_lp-1:0]       mask_r;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic [pend_w_lp-1:0]      pending_r;
    logic                      error_r;

    logic [31:0]               n_c;
    logic [cnt_w_lp-1:0]       mask_c;
    logic [cnt_w_lp-1:0]       first_c;
    logic [cnt_w_lp-1:0]       beat_idx;
    logic [fill_width_p-1:0]   beat_c;
    bp_bedrock_fill_header_s   hdr_c;
    bp_bedrock_resp_header_s   resp_c;

    logic req_fire, hdr_fire, data_fire, last_c;
    logic resp_fire, ack_ok, resp_bad;

    assign req_fire  = req_v_i & req_ready_and_o;
    assign hdr_fire  = lce_fill_header_v_o & lce_fill_header_ready_and_i;
    assign data_fire = lce_fill_data_v_o & lce_fill_data_ready_and_i;
    assign last_c    = (cnt_r == mask_r);

    // Beat count and wrap start for the incoming request
    always_comb begin
        n_c = (32'd1 << req_size_i) >> lg_fb_lp;
        if (n_c == 32'd0) n_c = 32'd1;
        if (n_c > 32'(beats_lp)) n_c = 32'(beats_lp);
        mask_c = cnt_w_lp'(n_c - 32'd1);
`ifdef BP_CCE_FILL_CRITICAL_FIRST_EN
        first_c = req_addr_i[lg_fb_lp +: cnt_w_lp];
`else
        first_c = req_addr_i[lg_fb_lp +: cnt_w_lp] & ~mask_c;
`endif
    end

    // Select the current beat within the wrapped window
    always_comb begin
        beat_idx = (first_r & ~mask_r) | ((first_r + cnt_r) & mask_r);
        beat_c   = data_r[beat_idx*fill_width_p +: fill_width_p];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_reset;
        else         state_r <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_reset:  state_n = e_ready;
            e_ready:  if (req_fire) state_n = e_header;
            e_header: if (hdr_fire) state_n = e_data;
            e_data:   if (data_fire & last_c) state_n = e_ready;
            default:  state_n = e_reset;
        endcase
    end

    // FSM-driven outputs; everything is quiet while reset is held
    always_comb begin
        req_ready_and_o     = 1'b0;
        lce_fill_header_v_o = 1'b0;
        lce_fill_has_data_o = 1'b0;
        lce_fill_data_v_o   = 1'b0;
        lce_fill_last_o     = 1'b0;
        lce_fill_data_o     = '0;
        hdr_c               = '0;
        if (!reset_i) begin
            unique case (state_r)
                e_ready: begin
                    req_ready_and_o = (pending_r < pend_w_lp'(pending_els_p));
                end
                e_header: begin
                    lce_fill_header_v_o    = 1'b1;
                    lce_fill_has_data_o    = 1'b1;
                    hdr_c.msg_type         = e_bedrock_fill_data;
                    hdr_c.addr             = addr_r;
                    hdr_c.size             = size_r;
                    hdr_c.payload.src_id   = cce_id_i;
                    hdr_c.payload.dst_id   = lce_r;
                    hdr_c.payload.way_id   = way_r;
                    hdr_c.payload.state    = coh_r;
                end
                e_data: begin
                    lce_fill_data_v_o = 1'b1;
                    lce_fill_data_o   = beat_c;
                    lce_fill_last_o   = last_c;
                end
                default: ;
            endcase
        end
    end

    assign lce_fill_header_o = hdr_c;

    // Request capture and beat counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_r  <= '0;
            size_r  <= e_bedrock_msg_size_1;
            lce_r   <= '0;
            way_r   <= '0;
            coh_r   <= e_COH_I;
            data_r  <= '0;
            first_r <= '0;
            mask_r  <= '0;
            cnt_r   <= '0;
        end else begin
            if (req_fire) begin
                addr_r  <= req_addr_i;
                size_r  <= bp_bedrock_msg_size_e'(req_size_i);
                lce_r   <= req_lce_id_i;
                way_r   <= req_way_id_i;
                coh_r   <= bp_coh_states_e'(req_state_i);
                data_r  <= req_data_i;
                first_r <= first_c;
                mask_r  <= mask_c;
            end
            if (hdr_fire)       cnt_r <= '0;
            else if (data_fire) cnt_r <= cnt_r + 1'b1;
        end
    end

    // Response channel: accept everything once out of reset
    assign resp_c = bp_bedrock_resp_header_s'(lce_resp_header_i);
    assign lce_resp_header_ready_and_o = ~reset_i & (state_r != e_reset);
    assign resp_fire = lce_resp_header_v_i & lce_resp_header_ready_and_o;
    assign ack_ok    = resp_fire
                     & (resp_c.msg_type == e_bedrock_resp_coh_ack)
                     & ~lce_resp_has_data_i
                     & (pending_r != '0);
    assign resp_bad  = resp_fire & ~ack_ok;

    assign ack_v_o      = ack_ok;
    assign ack_addr_o   = ack_ok ? resp_c.addr : '0;
    assign ack_lce_id_o = ack_ok ? resp_c.payload.src_id : '0;

    logic unused_resp;
    assign unused_resp = ^{resp_c.size, resp_c.payload.dst_id};

    // Outstanding fill counter; a header and an ack in one cycle cancel
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_r <= '0;
        end else begin
            unique case ({hdr_fire, ack_ok})
                2'b10:   pending_r <= pending_r + 1'b1;
                2'b01:   pending_r <= pending_r - 1'b1;
                default: pending_r <= pending_r;
            endcase
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk_i) begin
        if (reset_i)       error_r <= 1'b0;
        else if (resp_bad) error_r <= 1'b1;
    end

    assign pending_o = pending_r;
    assign error_o   = error_r;

endmodule

// File: tb/tb_bp_cce_fill_sender.sv
// tb_bp_cce_fill_sender: directed checks of fill burst order and ack tracking.
// Expected orders cover both settings of BP_CCE_FILL_CRITICAL_FIRST_EN.

module tb_bp_cce_fill_sender;
    import bp_cce_fill_pkg::*;

    localparam int hw_lp = $bits(bp_bedrock_fill_header_s);

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [3:0]   cce_id_i = 4'hA;
    logic         req_v_i = 1'b0;
    logic         req_ready_and_o;
    logic [39:0]  req_addr_i = '0;
    logic [2:0]   req_size_i = '0;
    logic [3:0]   req_lce_id_i = '0;
    logic [7:0]   req_way_id_i = '0;
    logic [2:0]   req_state_i = '0;
    logic [511:0] req_data_i = '0;
    logic [hw_lp-1:0] lce_fill_header_o;
    logic         lce_fill_header_v_o;
    logic         lce_fill_header_ready_and_i = 1'b0;
    logic         lce_fill_has_data_o;
    logic [63:0]  lce_fill_data_o;
    logic         lce_fill_data_v_o;
    logic         lce_fill_data_ready_and_i = 1'b0;
    logic         lce_fill_last_o;
    bp_bedrock_resp_header_s lce_resp_header_i = '0;
    logic         lce_resp_header_v_i = 1'b0;
    logic         lce_resp_header_ready_and_o;
    logic         lce_resp_has_data_i = 1'b0;
    logic         ack_v_o;
    logic [3:0]   ack_lce_id_o;
    logic [39:0]  ack_addr_o;
    logic [1:0]   pending_o;
    logic         error_o;

    int n_chk = 0;
    int n_err = 0;

    bp_cce_fill_sender dut (
        .clk_i                       (clk_i),
        .reset_i                     (reset_i),
        .cce_id_i                    (cce_id_i),
        .req_v_i                     (req_v_i),
        .req_ready_and_o             (req_ready_and_o),
        .req_addr_i                  (req_addr_i),
        .req_size_i                  (req_size_i),
        .req_lce_id_i                (req_lce_id_i),
        .req_way_id_i                (req_way_id_i),
        .req_state_i                 (req_state_i),
        .req_data_i                  (req_data_i),
        .lce_fill_header_o           (lce_fill_header_o),
        .lce_fill_header_v_o         (lce_fill_header_v_o),
        .lce_fill_header_ready_and_i (lce_fill_header_ready_and_i),
        .lce_fill_has_data_o         (lce_fill_has_data_o),
        .lce_fill_data_o             (lce_fill_data_o),
        .lce_fill_data_v_o           (lce_fill_data_v_o),
        .lce_fill_data_ready_and_i   (lce_fill_data_ready_and_i),
        .lce_fill_last_o             (lce_fill_last_o),
        .lce_resp_header_i           (lce_resp_header_i),
        .lce_resp_header_v_i         (lce_resp_header_v_i),
        .lce_resp_header_ready_and_o (lce_resp_header_ready_and_o),
        .lce_resp_has_data_i         (lce_resp_has_data_i),
        .ack_v_o                     (ack_v_o),
        .ack_lce_id_o                (ack_lce_id_o),
        .ack_addr_o                  (ack_addr_o),
        .pending_o                   (pending_o),
        .error_o                     (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word(input int k);
        return {32'hD000_0000 + 32'(k), 32'hCAFE_0000 + 32'(k)};
    endfunction

    function automatic logic [511:0] block();
        logic [511:0] b;
        for (int k = 0; k < 8; k++) b[k*64 +: 64] = word(k);
        return b;
    endfunction

    task automatic send_req(input logic [39:0] a, input logic [2:0] sz,
                            input logic [3:0] lce, input logic [7:0] way,
                            input logic [2:0] st);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_i);
            seen = req_ready_and_o;
        end
        chk("req_ready_wait", seen, 1'b1);
        req_addr_i   = a;
        req_size_i   = sz;
        req_lce_id_i = lce;
        req_way_id_i = way;
        req_state_i  = st;
        req_data_i   = block();
        req_v_i      = 1'b1;
        @(posedge clk_i);
        #1 req_v_i = 1'b0;
    endtask

    task automatic send_resp(input bp_bedrock_resp_type_e t, input bit hd,
                             input logic [39:0] a, input logic [3:0] lce,
                             input bit exp_ack);
        lce_resp_header_i                = '0;
        lce_resp_header_i.msg_type       = t;
        lce_resp_header_i.addr           = a;
        lce_resp_header_i.payload.src_id = lce;
        lce_resp_has_data_i              = hd;
        lce_resp_header_v_i              = 1'b1;
        #1;
        chk("resp_ready", lce_resp_header_ready_and_o, 1'b1);
        chk("ack_v", ack_v_o, exp_ack);
        if (exp_ack) begin
            chk("ack_addr", ack_addr_o, a);
            chk("ack_lce", ack_lce_id_o, lce);
        end
    endtask

    task automatic take_hdr(input logic [39:0] a, input logic [2:0] sz,
                            input logic [3:0] lce, input logic [7:0] way,
                            input logic [2:0] st, input bit with_ack,
                            input logic [39:0] ack_a, input logic [3:0] ack_l);
        bp_bedrock_fill_header_s h;
        @(negedge clk_i);
        h = bp_bedrock_fill_header_s'(lce_fill_header_o);
        chk("hdr_v", lce_fill_header_v_o, 1'b1);
        chk("hdr_has_data", lce_fill_has_data_o, 1'b1);
        chk("hdr_type", h.msg_type, e_bedrock_fill_data);
        chk("hdr_addr", h.addr, a);
        chk("hdr_size", h.size, sz);
        chk("hdr_src", h.payload.src_id, 4'hA);
        chk("hdr_dst", h.payload.dst_id, lce);
        chk("hdr_way", h.payload.way_id, way);
        chk("hdr_state", h.payload.state, st);
        lce_fill_header_ready_and_i = 1'b1;
        if (with_ack) send_resp(e_bedrock_resp_coh_ack, 1'b0, ack_a, ack_l, 1'b1);
        @(posedge clk_i);
        #1;
        lce_fill_header_ready_and_i = 1'b0;
        lce_resp_header_v_i = 1'b0;
    endtask

    task automatic beats(input int nb, input logic [23:0] ord, input bit stall,
                         input bit exp_rdy);
        int b;
        bit hold, rdy;
        logic [63:0] held;
        logic [2:0] ix;
        b = 0;
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 200 && b < nb; c++) begin
            @(negedge clk_i);
            chk("data_v", lce_fill_data_v_o, 1'b1);
            if (hold) chk("stall_stable", lce_fill_data_o, held);
            rdy = (stall && c < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy) begin
                ix = ord[3*b +: 3];
                chk("beat_data", lce_fill_data_o, word(int'(ix)));
                chk("beat_last", lce_fill_last_o, (b == nb-1));
                b++;
                hold = 1'b0;
            end else begin
                held = lce_fill_data_o;
                hold = 1'b1;
            end
            lce_fill_data_ready_and_i = rdy;
            @(posedge clk_i);
            #1 lce_fill_data_ready_and_i = 1'b0;
        end
        chk("beat_count", b, nb);
        @(negedge clk_i);
        chk("data_v_done", lce_fill_data_v_o, 1'b0);
        chk("req_ready_after", req_ready_and_o, exp_rdy);
    endtask

    initial begin : main
        logic [23:0] ord_a, ord_c, ord_d;
`ifdef BP_CCE_FILL_CRITICAL_FIRST_EN
        ord_a = {3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
        ord_c = {18'd0, 3'd6, 3'd7};
        ord_d = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
`else
        ord_a = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        ord_c = {18'd0, 3'd7, 3'd6};
        ord_d = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", req_ready_and_o, 1'b0);
        chk("rst_hdr_v", lce_fill_header_v_o, 1'b0);
        chk("rst_hdr", lce_fill_header_o, '0);
        chk("rst_data_v", lce_fill_data_v_o, 1'b0);
        chk("rst_data", lce_fill_data_o, '0);
        chk("rst_last", lce_fill_last_o, 1'b0);
        chk("rst_has_data", lce_fill_has_data_o, 1'b0);
        chk("rst_ack_v", ack_v_o, 1'b0);
        chk("rst_pending", pending_o, 2'd0);
        chk("rst_error", error_o, 1'b0);
        reset_i = 1'b0;
        #1 chk("e_reset_ready", req_ready_and_o, 1'b0);

        // 64B critical-word fill, then ack it
        send_req(40'h80_0000_0018, 3'd6, 4'd3, 8'h10, 3'd2);
        take_hdr(40'h80_0000_0018, 3'd6, 4'd3, 8'h10, 3'd2, 1'b0, '0, '0);
        beats(8, ord_a, 1'b0, 1'b1);
        chk("pend_a", pending_o, 2'd1);
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h80_0000_0018, 4'd3, 1'b1);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("pend_a_ack", pending_o, 2'd0);

        // 8B single-beat fill
        send_req(40'h28, 3'd3, 4'd1, 8'h01, 3'd1);
        take_hdr(40'h28, 3'd3, 4'd1, 8'h01, 3'd1, 1'b0, '0, '0);
        beats(1, {21'd0, 3'd5}, 1'b0, 1'b1);
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h28, 4'd1, 1'b1);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;

        // 16B two-beat wrap
        send_req(40'h38, 3'd4, 4'd2, 8'h02, 3'd6);
        take_hdr(40'h38, 3'd4, 4'd2, 8'h02, 3'd6, 1'b0, '0, '0);
        beats(2, ord_c, 1'b0, 1'b1);
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h38, 4'd2, 1'b1);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("pend_c_ack", pending_o, 2'd0);

        // Stalled 64B fill, then a second fill fills the pending window
        send_req(40'h1030, 3'd6, 4'd5, 8'h80, 3'd2);
        take_hdr(40'h1030, 3'd6, 4'd5, 8'h80, 3'd2, 1'b0, '0, '0);
        beats(8, ord_d, 1'b1, 1'b1);
        send_req(40'h0, 3'd3, 4'd6, 8'h04, 3'd1);
        take_hdr(40'h0, 3'd3, 4'd6, 8'h04, 3'd1, 1'b0, '0, '0);
        beats(1, 24'd0, 1'b0, 1'b0);
        chk("pend_full", pending_o, 2'd2);
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h1030, 4'd5, 1'b1);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("ready_after_ack", req_ready_and_o, 1'b1);
        chk("pend_after_ack", pending_o, 2'd1);

        // Ack for the 8B fill lands with the next header handshake
        send_req(40'h100, 3'd3, 4'd7, 8'h08, 3'd2);
        take_hdr(40'h100, 3'd3, 4'd7, 8'h08, 3'd2, 1'b1, 40'h0, 4'd6);
        chk("pend_same_cycle", pending_o, 2'd1);
        beats(1, 24'd0, 1'b0, 1'b1);
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h100, 4'd7, 1'b1);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("pend_zero", pending_o, 2'd0);

        // coh_ack with nothing pending
        send_resp(e_bedrock_resp_coh_ack, 1'b0, 40'h40, 4'd1, 1'b0);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("err_nopend", error_o, 1'b1);
        chk("err_nopend_pend", pending_o, 2'd0);
        repeat (3) @(negedge clk_i);
        chk("err_sticky", error_o, 1'b1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("err_cleared", error_o, 1'b0);

        // Wrong response type
        @(negedge clk_i);
        send_resp(e_bedrock_resp_inv_ack, 1'b0, 40'h80, 4'd2, 1'b0);
        @(negedge clk_i);
        lce_resp_header_v_i = 1'b0;
        chk("err_type", error_o, 1'b1);
        chk("err_type_pend", pending_o, 2'd0);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;

        // Reset in the middle of a burst
        send_req(40'h80_0000_0018, 3'd6, 4'd3, 8'h10, 3'd2);
        take_hdr(40'h80_0000_0018, 3'd6, 4'd3, 8'h10, 3'd2, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("mid_data_v", lce_fill_data_v_o, 1'b1);
            lce_fill_data_ready_and_i = 1'b1;
            @(posedge clk_i);
            #1 lce_fill_data_ready_and_i = 1'b0;
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        lce_fill_data_ready_and_i = 1'b1;
        #1 chk("mid_rst_data_v", lce_fill_data_v_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        lce_fill_data_ready_and_i = 1'b0;
        chk("mid_rst_pend", pending_o, 2'd0);
        @(negedge clk_i);
        chk("post_rst_data_v", lce_fill_data_v_o, 1'b0);
        chk("post_rst_hdr_v", lce_fill_header_v_o, 1'b0);
        chk("post_rst_ready", req_ready_and_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
